// File: rtl/axis_packet_receiver.sv
// AXI-Stream packet receiver: buffers beats in a first-word-fall-through FIFO,
// checks each packet's length against PKT_LEN and counts completed packets.
module axis_packet_receiver #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [7:0]               pkt_count,
  output logic                     len_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Beat counter only needs to reach PKT_LEN-1 before the packet closes.
  localparam int unsigned CW = (PKT_LEN < 2) ? 1 : $clog2(PKT_LEN);

  localparam logic [AW:0] FullLevel   = (AW + 1)'(DEPTH);
  localparam logic [CW:0] PktLenC     = (CW + 1)'(PKT_LEN);
  localparam logic        SingleBeat  = (PKT_LEN == 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]        pkt_count_q, pkt_count_d;
  logic              len_err_q, len_err_d;

  logic              push, pop;
  logic [CW:0]       beat_inc;
  logic [DATA_W:0]   head;

  // Handshakes; ready depends only on registered level so there is no
  // combinational path from s_tvalid or out_ready.
  always_comb begin
    s_tready  = !rst && (level_q != FullLevel);
    out_valid = (level_q != '0);
    push      = s_tvalid && s_tready;
    pop       = out_valid && out_ready;
    head      = mem_q[rd_ptr_q];
    out_data  = head[DATA_W-1:0];
    out_last  = head[DATA_W];
    level     = level_q;
    pkt_count = pkt_count_q;
    len_err   = len_err_q;
  end

  // FIFO storage write; push is already gated off during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Length-check FSM next-state; advances only on accepted beats.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    len_err_d   = 1'b0;
    beat_inc    = {1'b0, beat_cnt_q} + 1'b1;
    if (push) begin
      case (state_q)
        StIdle: begin
          if (s_tlast) begin
            pkt_count_d = pkt_count_q + 1'b1;
            len_err_d   = !SingleBeat;
          end else begin
            state_d    = StRecv;
            beat_cnt_d = CW'(1);
          end
        end
        StRecv: begin
          if (s_tlast) begin
            state_d     = StIdle;
            beat_cnt_d  = '0;
            pkt_count_d = pkt_count_q + 1'b1;
            len_err_d   = (beat_inc != PktLenC);
          end else if (beat_inc == PktLenC) begin
            // Missing tlast: close the packet here; later beats start a new one.
            state_d    = StIdle;
            beat_cnt_d = '0;
            len_err_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_inc[CW-1:0];
          end
        end
        default: begin
          state_d    = StIdle;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset flushes the FIFO and any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axis_packet_receiver.sv
// Directed self-checking bench for axis_packet_receiver (DATA_W=8, DEPTH=8, PKT_LEN=4).
module tb_axis_packet_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       s_tready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [7:0] pkt_count;
  logic       len_err;
  logic [3:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int err_base;
  int max_lvl;
  int tready_drops;

  logic [8:0] exp_q [$];
  logic [8:0] exp_head;
  logic       hold_prev = 1'b0;
  logic [8:0] held_beat;

  axis_packet_receiver #(
    .DATA_W (8),
    .DEPTH  (8),
    .PKT_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .pkt_count(pkt_count),
    .len_err  (len_err),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: checks popped beats against the scoreboard, head stability, counts len_err.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(out_data), 32'hFFFF);
      end else begin
        exp_head = exp_q.pop_front();
        check("pop_data", 32'(out_data), 32'(exp_head[7:0]));
        check("pop_last", 32'(out_last), 32'(exp_head[8]));
      end
    end
    if (!rst && hold_prev && out_valid)
      check("hold_stable", 32'({out_last, out_data}), 32'(held_beat));
    hold_prev = !rst && out_valid && !out_ready;
    held_beat = {out_last, out_data};
    if (len_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one beat; returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        exp_q.push_back({last, d});
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (level == 0 && exp_q.size() == 0) break;
      tick(1);
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_level", 32'(level), 0);
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tlast   = 1'b0;
    out_ready = 1'b0;
    tick(2);
    check("rst_tready", 32'(s_tready), 0);
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pkt", 32'(pkt_count), 0);
    check("rst_lenerr", 32'(len_err), 0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", 32'(s_tready), 1);

    // 1: one good packet, fall-through latency of one cycle.
    out_ready = 1'b1;
    err_base = err_cnt;
    for (int i = 1; i <= 4; i++) begin
      send(8'hA0 + 8'(i), i == 4);
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'hA0 + 32'(i));
    end
    idle();
    check("t1_pkt", 32'(pkt_count), 1);
    drain();
    check("t1_noerr", err_cnt - err_base, 0);

    // 2: fill to full with consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), (i % 4) == 3);
    idle();
    check("t2_tready_full", 32'(s_tready), 0);
    check("t2_level_full", 32'(level), 8);
    out_ready = 1'b1;
    tick(1);
    check("t2_tready_after_pop", 32'(s_tready), 1);
    check("t2_level_after_pop", 32'(level), 7);
    drain();
    check("t2_pkt", 32'(pkt_count), 2);

    // 3: short packet.
    do_reset();
    out_ready = 1'b1;
    err_base = err_cnt;
    send(8'hB1, 1'b0);
    check("t3_lenerr_b1", 32'(len_err), 0);
    send(8'hB2, 1'b1);
    idle();
    check("t3_lenerr", 32'(len_err), 1);
    check("t3_pkt", 32'(pkt_count), 1);
    tick(1);
    check("t3_lenerr_pulse", 32'(len_err), 0);
    drain();
    check("t3_errcnt", err_cnt - err_base, 1);

    // 4: missing tlast, then a good packet.
    do_reset();
    out_ready = 1'b1;
    err_base = err_cnt;
    for (int i = 1; i <= 4; i++) send(8'hC0 + 8'(i), 1'b0);
    check("t4_lenerr_c", 32'(len_err), 1);
    check("t4_pkt_c", 32'(pkt_count), 0);
    for (int i = 1; i <= 4; i++) send(8'hD0 + 8'(i), i == 4);
    idle();
    check("t4_lenerr_d", 32'(len_err), 0);
    check("t4_pkt_d", 32'(pkt_count), 1);
    drain();
    check("t4_errcnt", err_cnt - err_base, 1);

    // 5: 40 beats streamed through with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    err_base = err_cnt;
    max_lvl = 0;
    tready_drops = 0;
    for (int i = 0; i < 40; i++) begin
      send(8'(i + 32), (i % 4) == 3);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (!s_tready) tready_drops++;
    end
    idle();
    check("t5_maxlvl", max_lvl, 1);
    check("t5_tready", tready_drops, 0);
    check("t5_pkt", 32'(pkt_count), 10);
    drain();
    check("t5_noerr", err_cnt - err_base, 0);

    // 6: reset mid-packet, following from pkt_count=10.
    out_ready = 1'b0;
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    idle();
    check("t6_level_pre", 32'(level), 2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_tready_in_rst", 32'(s_tready), 0);
    tick(1);
    rst = 1'b0;
    check("t6_level", 32'(level), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_pkt", 32'(pkt_count), 0);
    out_ready = 1'b1;
    err_base = err_cnt;
    for (int i = 1; i <= 4; i++) send(8'hF0 + 8'(i), i == 4);
    idle();
    check("t6_pkt_after", 32'(pkt_count), 1);
    check("t6_lenerr", 32'(len_err), 0);
    drain();
    check("t6_noerr", err_cnt - err_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
